// File: rtl/trisc_seq_pkg.sv
// ============================================================================
// trisc_seq_pkg
//   States, opcode bit positions and control-word constants for the TRISC
//   fetch/decode/execute sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package trisc_seq_pkg;

  typedef enum logic [4:0] {
    S_RST     = 5'd0,
    S_FETCH_A = 5'd1,
    S_FETCH_M = 5'd2,
    S_DECODE  = 5'd3,
    S_EX_INC  = 5'd4,
    S_EX_CLR  = 5'd5,
    S_LD_A    = 5'd6,
    S_LD_M    = 5'd7,
    S_LD_W    = 5'd8,
    S_ST_A    = 5'd9,
    S_ST_M    = 5'd10,
    S_AD_A    = 5'd11,
    S_AD_M    = 5'd12,
    S_AD_W    = 5'd13,
    S_EX_JMP  = 5'd14,
    S_TRAP    = 5'd15,
    S_HALT    = 5'd16
  } state_t;

  typedef enum logic [3:0] {
    OPC_ILL = 4'd0,
    OPC_LDA = 4'd1,
    OPC_STA = 4'd2,
    OPC_ADD = 4'd3,
    OPC_JMP = 4'd4,
    OPC_JZ  = 4'd5,
    OPC_INC = 4'd6,
    OPC_CLR = 4'd7,
    OPC_HLT = 4'd8
  } op_class_t;

  localparam int OP_LDA = 10;
  localparam int OP_STA = 9;
  localparam int OP_ADD = 8;
  localparam int OP_JMP = 7;
  localparam int OP_JZ  = 6;
  localparam int OP_INC = 5;
  localparam int OP_CLR = 4;
  localparam int OP_HLT = 3;
  localparam int OP_LO  = 3;
  localparam int OP_HI  = 10;

  localparam int C_INIT  = 0;
  localparam int C_IRLD  = 2;
  localparam int C_PCMAR = 3;
  localparam int C_MRD   = 4;
  localparam int C_MWR   = 5;
  localparam int C_PCINC = 7;
  localparam int C_ACLR  = 8;
  localparam int C_AINC  = 9;
  localparam int C_ALD   = 11;
  localparam int C_AADD  = 12;
  localparam int C_PCLD  = 13;
  localparam int C_TRAP  = 14;
  localparam int C_IRMAR = 15;

  localparam logic [15:0] CTL_RST     = 16'd1 << C_INIT;
  localparam logic [15:0] CTL_FETCH_A = 16'd1 << C_PCMAR;
  localparam logic [15:0] CTL_FETCH_M = (16'd1 << C_PCMAR) | (16'd1 << C_MRD);
  localparam logic [15:0] CTL_DECODE  = (16'd1 << C_IRLD) | (16'd1 << C_PCINC);
  localparam logic [15:0] CTL_EX_INC  = 16'd1 << C_AINC;
  localparam logic [15:0] CTL_EX_CLR  = 16'd1 << C_ACLR;
  localparam logic [15:0] CTL_ADDR    = 16'd1 << C_IRMAR;
  localparam logic [15:0] CTL_RD_M    = 16'd1 << C_MRD;
  localparam logic [15:0] CTL_ST_M    = (16'd1 << C_MRD) | (16'd1 << C_MWR);
  localparam logic [15:0] CTL_LD_W    = 16'd1 << C_ALD;
  localparam logic [15:0] CTL_AD_W    = 16'd1 << C_AADD;
  localparam logic [15:0] CTL_EX_JMP  = 16'd1 << C_PCLD;
  localparam logic [15:0] CTL_TRAP    = 16'd1 << C_TRAP;

  function automatic logic [15:0] state_ctl(input state_t s);
    logic [15:0] c;
    c = 16'h0000;
    case (s)
      S_RST:                c = CTL_RST;
      S_FETCH_A:            c = CTL_FETCH_A;
      S_FETCH_M:            c = CTL_FETCH_M;
      S_DECODE:             c = CTL_DECODE;
      S_EX_INC:             c = CTL_EX_INC;
      S_EX_CLR:             c = CTL_EX_CLR;
      S_LD_A, S_ST_A, S_AD_A: c = CTL_ADDR;
      S_LD_M, S_AD_M:       c = CTL_RD_M;
      S_ST_M:               c = CTL_ST_M;
      S_LD_W:               c = CTL_LD_W;
      S_AD_W:               c = CTL_AD_W;
      S_EX_JMP:             c = CTL_EX_JMP;
      S_TRAP:               c = CTL_TRAP;
      default:              c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trisc_op_decode.sv
// ============================================================================
// trisc_op_decode
//   One-hot opcode check: exactly one bit set, and only within bits 10..3.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module trisc_op_decode
  import trisc_seq_pkg::*;
#(
  parameter int OPW = 11
) (
  input  logic [OPW-1:0] op,
  output op_class_t      op_class,
  output logic           legal
);

  localparam logic [OPW-1:0] USED_MASK = OPW'(8'hFF) << OP_LO;

  logic [7:0] field;
  logic       outside;

  assign field   = op[OP_HI:OP_LO];
  assign outside = |(op & ~USED_MASK);
  assign legal   = !outside && (field != 8'd0) && ((field & (field - 8'd1)) == 8'd0);

  always_comb begin
    op_class = OPC_ILL;
    if (legal) begin
      case (field)
        8'(1 << (OP_LDA - OP_LO)): op_class = OPC_LDA;
        8'(1 << (OP_STA - OP_LO)): op_class = OPC_STA;
        8'(1 << (OP_ADD - OP_LO)): op_class = OPC_ADD;
        8'(1 << (OP_JMP - OP_LO)): op_class = OPC_JMP;
        8'(1 << (OP_JZ  - OP_LO)): op_class = OPC_JZ;
        8'(1 << (OP_INC - OP_LO)): op_class = OPC_INC;
        8'(1 << (OP_CLR - OP_LO)): op_class = OPC_CLR;
        8'(1 << (OP_HLT - OP_LO)): op_class = OPC_HLT;
        default:                   op_class = OPC_ILL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/trisc_ctrl_seq.sv
// ============================================================================
// trisc_ctrl_seq
//   Moore fetch/decode/execute sequencer for the TRISC datapath; falling-edge
//   state, async active-low CLR. Optional macro TRISC_SEQ_MEM_TIMEOUT_EN adds a
//   mem_rdy wait timeout that traps after WAIT_MAX stalled cycles.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module trisc_ctrl_seq
  import trisc_seq_pkg::*;
#(
  parameter int OPW      = 11,
  parameter int CW       = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic [OPW-1:0] op,
  input  logic           mem_rdy,
  input  logic           zero,
  output logic [CW-1:0]  control,
  output logic [4:0]     state_o,
  output logic           illegal,
  output logic           halted
);

  state_t    state_q, state_d;
  logic      illegal_q, illegal_d;
  op_class_t op_class;
  logic      op_legal;
  logic      timeout;

  trisc_op_decode #(.OPW(OPW)) u_op_decode (
    .op       (op),
    .op_class (op_class),
    .legal    (op_legal)
  );

`ifdef TRISC_SEQ_MEM_TIMEOUT_EN
  localparam int WCW_RAW = $clog2(WAIT_MAX + 1);
  localparam int WCW     = (WCW_RAW < 4) ? 4 : WCW_RAW;

  logic [WCW-1:0] wait_q, wait_d;
  logic           in_mem;

  assign in_mem  = (state_q == S_FETCH_M) || (state_q == S_LD_M) ||
                   (state_q == S_ST_M)    || (state_q == S_AD_M);
  // wait_q counts stalled cycles already spent; the WAIT_MAX-th one traps
  assign timeout = in_mem && (wait_q == WCW'(WAIT_MAX - 1));

  always_comb begin
    wait_d = '0;
    if (in_mem && !mem_rdy && !timeout) wait_d = wait_q + 1'b1;
  end

  always_ff @(negedge CLK or negedge CLR) begin
    if (!CLR) wait_q <= '0;
    else      wait_q <= wait_d;
  end
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX != 0);
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RST:     state_d = S_FETCH_A;
      S_FETCH_A: state_d = S_FETCH_M;
      S_FETCH_M: state_d = mem_rdy ? S_DECODE : (timeout ? S_TRAP : S_FETCH_M);
      S_DECODE: begin
        if (!op_legal) begin
          state_d = S_TRAP;
        end else begin
          case (op_class)
            OPC_INC: state_d = S_EX_INC;
            OPC_CLR: state_d = S_EX_CLR;
            OPC_LDA: state_d = S_LD_A;
            OPC_STA: state_d = S_ST_A;
            OPC_ADD: state_d = S_AD_A;
            OPC_JMP: state_d = S_EX_JMP;
            OPC_JZ:  state_d = zero ? S_EX_JMP : S_FETCH_A;
            OPC_HLT: state_d = S_HALT;
            default: state_d = S_TRAP;
          endcase
        end
      end
      S_EX_INC, S_EX_CLR, S_LD_W, S_AD_W, S_EX_JMP: state_d = S_FETCH_A;
      S_LD_A:    state_d = S_LD_M;
      S_LD_M:    state_d = mem_rdy ? S_LD_W : (timeout ? S_TRAP : S_LD_M);
      S_ST_A:    state_d = S_ST_M;
      S_ST_M:    state_d = mem_rdy ? S_FETCH_A : (timeout ? S_TRAP : S_ST_M);
      S_AD_A:    state_d = S_AD_M;
      S_AD_M:    state_d = mem_rdy ? S_AD_W : (timeout ? S_TRAP : S_AD_M);
      S_TRAP: begin
        state_d   = S_FETCH_A;
        illegal_d = 1'b1;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RST;
    endcase
  end

  always_ff @(negedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign control = CW'(state_ctl(state_q));
  assign state_o = state_q;
  assign illegal = illegal_q;
  assign halted  = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_trisc_ctrl_seq.sv
// ============================================================================
// tb_trisc_ctrl_seq
//   Instruction-level trace model of the TRISC sequencer driving and checking
//   the control word, illegal and halted outputs cycle by cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trisc_ctrl_seq;

  localparam int OPW      = 11;
  localparam int CW       = 16;
  localparam int WAIT_MAX = 8;

  localparam logic [OPW-1:0] OP_LDA = OPW'(1) << 10;
  localparam logic [OPW-1:0] OP_STA = OPW'(1) << 9;
  localparam logic [OPW-1:0] OP_ADD = OPW'(1) << 8;
  localparam logic [OPW-1:0] OP_JMP = OPW'(1) << 7;
  localparam logic [OPW-1:0] OP_JZ  = OPW'(1) << 6;
  localparam logic [OPW-1:0] OP_INC = OPW'(1) << 5;
  localparam logic [OPW-1:0] OP_CLR = OPW'(1) << 4;
  localparam logic [OPW-1:0] OP_HLT = OPW'(1) << 3;

  logic           CLK = 1'b0;
  logic           CLR = 1'b0;
  logic [OPW-1:0] op = '0;
  logic           mem_rdy = 1'b0;
  logic           zero = 1'b0;
  logic [CW-1:0]  control;
  logic [4:0]     dbg_state_unused;
  logic           illegal;
  logic           halted;

  trisc_ctrl_seq #(.OPW(OPW), .CW(CW), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .op      (op),
    .mem_rdy (mem_rdy),
    .zero    (zero),
    .control (control),
    .state_o (dbg_state_unused),
    .illegal (illegal),
    .halted  (halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit             rdy;
    logic [OPW-1:0] op;
    bit             zero;
    logic [15:0]    ctl;
    bit             ill;
    bit             hlt;
  } rec_t;

  rec_t q[$];
  bit   m_ill;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic bit rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [OPW-1:0] rnd_op();
    return OPW'($urandom);
  endfunction

  function automatic bit is_legal(input logic [OPW-1:0] v);
    int n;
    int pos;
    n = 0;
    pos = -1;
    for (int i = 0; i < OPW; i++) if (v[i]) begin n++; pos = i; end
    return (n == 1) && (pos >= 3) && (pos <= 10);
  endfunction

  task automatic push(input bit rdy, input logic [OPW-1:0] o, input bit z,
                      input logic [15:0] c, input bit h);
    rec_t r;
    r.rdy = rdy; r.op = o; r.zero = z; r.ctl = c; r.ill = m_ill; r.hlt = h;
    q.push_back(r);
  endtask

  // mem_rdy, op and zero are don't-care outside the states that sample them
  task automatic push_idle(input logic [15:0] c);
    push(rbit(), rnd_op(), rbit(), c, 1'b0);
  endtask

  task automatic push_trap();
    push_idle(16'h4000);
    m_ill = 1'b1;
  endtask

  task automatic mem_phase(input int w, input logic [15:0] c, output bit aborted);
    aborted = 1'b0;
`ifdef TRISC_SEQ_MEM_TIMEOUT_EN
    if (w >= WAIT_MAX) begin
      for (int i = 0; i < WAIT_MAX; i++) push(1'b0, rnd_op(), rbit(), c, 1'b0);
      push_trap();
      aborted = 1'b1;
      return;
    end
`endif
    for (int i = 0; i < w; i++) push(1'b0, rnd_op(), rbit(), c, 1'b0);
    push(1'b1, rnd_op(), rbit(), c, 1'b0);
  endtask

  task automatic model_instr(input logic [OPW-1:0] o, input bit z, input int wf, input int wm);
    bit ab;
    push_idle(16'h0008);
    mem_phase(wf, 16'h0018, ab);
    if (ab) return;
    push(rbit(), o, z, 16'h0084, 1'b0);
    if (!is_legal(o)) begin
      push_trap();
      return;
    end
    case (o)
      OP_INC: push_idle(16'h0200);
      OP_CLR: push_idle(16'h0100);
      OP_JMP: push_idle(16'h2000);
      OP_JZ:  if (z) push_idle(16'h2000);
      OP_LDA: begin
        push_idle(16'h8000);
        mem_phase(wm, 16'h0010, ab);
        if (!ab) push_idle(16'h0800);
      end
      OP_STA: begin
        push_idle(16'h8000);
        mem_phase(wm, 16'h0030, ab);
      end
      OP_ADD: begin
        push_idle(16'h8000);
        mem_phase(wm, 16'h0010, ab);
        if (!ab) push_idle(16'h1000);
      end
      OP_HLT: for (int i = 0; i < 20; i++) push(rbit(), rnd_op(), rbit(), 16'h0000, 1'b1);
      default: ;
    endcase
  endtask

  task automatic run_queue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge CLK);
      op = r.op; zero = r.zero; mem_rdy = r.rdy;
      #1;
      n_cmp++;
      if (control !== CW'(r.ctl)) begin
        n_bad++;
        $display("FAIL control: got %h want %h at %0t", control, r.ctl, $time);
      end
      n_cmp++;
      if (illegal !== r.ill) begin
        n_bad++;
        $display("FAIL illegal: got %b want %b at %0t", illegal, r.ill, $time);
      end
      n_cmp++;
      if (halted !== r.hlt) begin
        n_bad++;
        $display("FAIL halted: got %b want %b at %0t", halted, r.hlt, $time);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (control !== CW'(16'h0001) || illegal !== 1'b0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got ctl=%h ill=%b hlt=%b want ctl=0001 ill=0 hlt=0", tag, control, illegal, halted);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    m_ill = 1'b0;
    #1;
    check_reset_outputs("reset_release");
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    op = rnd_op(); mem_rdy = rbit(); zero = rbit();
    CLR = 1'b0;
    #1;
    check_reset_outputs("reset_assert");
    release_reset();
  endtask

  task automatic test_reset();
    do_reset();
    model_instr(OP_INC, 1'b0, 0, 0);
    model_instr(OP_CLR, 1'b1, 0, 0);
    model_instr(OP_JMP, 1'b0, 0, 0);
    run_queue();
  endtask

  task automatic test_mem_wait();
    do_reset();
    model_instr(OP_LDA, 1'b0, 0, 3);
    model_instr(OP_INC, 1'b0, 0, 0);
    model_instr(OP_STA, 1'b0, 2, 0);
    model_instr(OP_STA, 1'b1, 0, 4);
    model_instr(OP_ADD, 1'b0, 1, 2);
    model_instr(OP_ADD, 1'b1, 0, 0);
    run_queue();
  endtask

  task automatic test_jz();
    do_reset();
    model_instr(OP_JZ, 1'b0, 0, 0);
    model_instr(OP_JZ, 1'b1, 0, 0);
    model_instr(OP_INC, 1'b0, 0, 0);
    run_queue();
  endtask

  task automatic test_illegal();
    do_reset();
    model_instr(OP_INC, 1'b0, 0, 0);
    model_instr(11'b00000110000, 1'b0, 0, 0);
    model_instr(OP_INC, 1'b0, 0, 0);
    model_instr(OP_LDA, 1'b0, 1, 1);
    run_queue();
    do_reset();
    model_instr(11'b00000000000, 1'b0, 0, 0);
    model_instr(OP_INC, 1'b0, 0, 0);
    run_queue();
    do_reset();
    model_instr(11'b00000000100, 1'b0, 0, 0);
    model_instr(OP_INC | 11'b1, 1'b0, 0, 0);
    model_instr(OP_CLR, 1'b0, 0, 0);
    run_queue();
  endtask

  task automatic test_halt_midreset();
    bit ab;
    do_reset();
    model_instr(OP_INC, 1'b0, 0, 0);
    model_instr(OP_HLT, 1'b0, 0, 0);
    run_queue();
    do_reset();
    push_idle(16'h0008);
    mem_phase(0, 16'h0018, ab);
    push(rbit(), OP_STA, rbit(), 16'h0084, 1'b0);
    push_idle(16'h8000);
    push(1'b0, rnd_op(), rbit(), 16'h0030, 1'b0);
    push(1'b0, rnd_op(), rbit(), 16'h0030, 1'b0);
    run_queue();
    @(posedge CLK);
    mem_rdy = 1'b0;
    #1;
    n_cmp++;
    if (control !== CW'(16'h0030)) begin
      n_bad++;
      $display("FAIL st_m_hold: got %h want 0030", control);
    end
    #1;
    CLR = 1'b0;
    #1;
    check_reset_outputs("midaccess_reset");
    release_reset();
    model_instr(OP_INC, 1'b0, 0, 0);
    run_queue();
  endtask

  task automatic test_mem_timeout();
    do_reset();
    model_instr(OP_INC, 1'b0, WAIT_MAX, 0);
    model_instr(OP_INC, 1'b0, WAIT_MAX - 1, 0);
    model_instr(OP_LDA, 1'b0, 0, WAIT_MAX);
    model_instr(OP_ADD, 1'b0, 0, WAIT_MAX + 2);
    model_instr(OP_STA, 1'b0, 0, WAIT_MAX - 1);
    model_instr(OP_INC, 1'b0, 0, 0);
    run_queue();
  endtask

  task automatic test_random();
    logic [OPW-1:0] pool [12];
    pool[0] = OP_LDA; pool[1] = OP_STA; pool[2] = OP_ADD; pool[3] = OP_JMP;
    pool[4] = OP_JZ;  pool[5] = OP_INC; pool[6] = OP_CLR; pool[7] = OP_JZ;
    pool[8] = OP_INC; pool[9] = OP_LDA;
    pool[10] = '0;    pool[11] = '0;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [OPW-1:0] o;
      int k;
      k = $urandom_range(0, 11);
      o = (k >= 10) ? rnd_op() & ~OP_HLT : pool[k];
      model_instr(o, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_queue();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ill = 1'b0;
    test_reset();
    test_mem_wait();
    test_jz();
    test_illegal();
    test_halt_midreset();
    test_mem_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
